// File: rtl/loader_pkg.sv
// loader_pkg: shared state type and width defaults for the data memory boot loader
package loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} loader_state_t;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;
endpackage

// File: rtl/run_watchdog.sv
// run_watchdog: RUN cycle counter with clear and enable, flags the watchdog limit
module run_watchdog
  import loader_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int MAX_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cycles_o,
  output logic          at_max_o
);
  logic [CW-1:0] cycles_q, cycles_d;
  // clear wins over counting; holding en_i low freezes the count
  always_comb cycles_d = clr_i ? '0 : en_i ? cycles_q + 1'b1 : cycles_q;
  // counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) cycles_q <= '0;
    else cycles_q <= cycles_d;
  assign cycles_o = cycles_q;
  assign at_max_o = cycles_q == CW'(MAX_CYCLES);
endmodule

// File: rtl/dmem_loader.sv
// dmem_loader: streams bytes into data memory, then runs the core under a watchdog
module dmem_loader
  import loader_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int MAX_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);
  loader_state_t state_q;
  logic [AW:0]   cnt_q, len_q;
  logic          in_ready_q, wr_en_q, core_reset_q, busy_q, finished_q, timed_out_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dat_q;
  logic          at_max, wd_clr, wd_en;
  assign wd_clr = start && (state_q == IDLE || state_q == HALT);
  assign wd_en  = state_q == RUN && !core_done && !at_max;
  run_watchdog #(.CW(CW), .MAX_CYCLES(MAX_CYCLES)) u_wd (
    .clk(clk), .reset(reset), .clr_i(wd_clr), .en_i(wd_en),
    .cycles_o(cycles), .at_max_o(at_max)
  );
  // control FSM with a one-cycle registered write pipeline
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      dat_q        <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, HALT: if (start) begin
          cnt_q       <= '0;
          len_q       <= load_len;
          finished_q  <= 1'b0;
          timed_out_q <= 1'b0;
          busy_q      <= 1'b1;
          if (load_len == '0) begin
            state_q      <= RUN;
            core_reset_q <= 1'b0;
          end else begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
          end
        end
        LOAD: if (in_valid && in_ready_q) begin
          wr_en_q <= 1'b1;
          addr_q  <= cnt_q[AW-1:0];
          dat_q   <= in_data;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            in_ready_q   <= 1'b0;
            state_q      <= RUN;
            core_reset_q <= 1'b0;
          end
        end
        RUN: if (core_done || at_max) begin
          state_q      <= HALT;
          core_reset_q <= 1'b1;
          busy_q       <= 1'b0;
          finished_q   <= core_done;
          timed_out_q  <= !core_done;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign in_ready   = in_ready_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_addr   = addr_q;
  assign mem_dat    = dat_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign timed_out  = timed_out_q;
endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: scoreboard bench for load, run, timeout and abort sequences
module tb_dmem_loader;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, core_done = 1'b0;
  logic [8:0]  load_len = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_wr_en, core_reset, busy, finished, timed_out;
  logic [7:0]  mem_addr, mem_dat;
  logic [15:0] cycles;
  int compared = 0, mismatched = 0;
  int addr_exp = 0;
  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];

  dmem_loader #(.AW(8), .DW(8), .CW(16), .MAX_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat(mem_dat),
    .core_reset(core_reset), .core_done(core_done), .busy(busy),
    .finished(finished), .timed_out(timed_out), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // every write the DUT produces must match the oldest expected write
  always @(negedge clk)
    if (mem_wr_en) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: addr=%0h dat=%0h, none required", mem_addr, mem_dat);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_dat !== e.d) begin
          mismatched++;
          $display("FAIL write: addr=%0h dat=%0h, required addr=%0h dat=%0h", mem_addr, mem_dat, e.a, e.d);
        end
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    load_len = 9'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data = b;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL in_ready_feed: got %b, required 1", in_ready);
    end else begin
      exp_q.push_back('{8'(addr_exp), b});
      addr_exp++;
    end
    tick();
  endtask

  task automatic check_drained(input string name);
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL %s_drained: %0d writes pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    compared++;
    if ({core_reset, in_ready, mem_wr_en, busy, finished, timed_out, mem_addr, mem_dat, cycles} !== {1'b1, 5'b0, 32'b0}) begin
      mismatched++;
      $display("FAIL reset_values: cr=%b rdy=%b we=%b busy=%b fin=%b to=%b addr=%0h dat=%0h cyc=%0d, required cr=1 rest 0",
               core_reset, in_ready, mem_wr_en, busy, finished, timed_out, mem_addr, mem_dat, cycles);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_load;
    addr_exp = 0;
    in_valid = 1'b1;
    in_data = 8'hA5;
    do_start(3);
    compared++;
    if ({in_ready, busy, core_reset, mem_wr_en} !== 4'b1110) begin
      mismatched++;
      $display("FAIL basic_after_start: rdy/busy/cr/we=%b, required 1110", {in_ready, busy, core_reset, mem_wr_en});
    end
    feed(8'hA5, 1'b0);
    feed(8'h3C, 1'b0);
    compared++;
    if (core_reset !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_core_reset_early: got %b, required 1", core_reset);
    end
    feed(8'hFF, 1'b0);
    compared++;
    if ({core_reset, in_ready, mem_wr_en, mem_addr} !== {3'b001, 8'd2}) begin
      mismatched++;
      $display("FAIL basic_last_write: cr=%b rdy=%b we=%b addr=%0d, required cr=0 rdy=0 we=1 addr=2",
               core_reset, in_ready, mem_wr_en, mem_addr);
    end
  endtask

  task automatic test_done;
    for (int i = 0; i < 10; i++) tick();
    in_valid = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    compared++;
    if ({finished, timed_out, core_reset, busy, cycles} !== {4'b1010, 16'd10}) begin
      mismatched++;
      $display("FAIL done_halt: fin=%b to=%b cr=%b busy=%b cyc=%0d, required fin=1 to=0 cr=1 busy=0 cyc=10",
               finished, timed_out, core_reset, busy, cycles);
    end
    tick();
    tick();
    compared++;
    if (cycles !== 16'd10) begin
      mismatched++;
      $display("FAIL done_frozen: cycles=%0d, required 10", cycles);
    end
    check_drained("done");
  endtask

  task automatic test_gaps;
    addr_exp = 0;
    do_start(3);
    compared++;
    if ({finished, cycles, in_ready} !== {1'b0, 16'd0, 1'b1}) begin
      mismatched++;
      $display("FAIL restart_clear: fin=%b cyc=%0d rdy=%b, required fin=0 cyc=0 rdy=1", finished, cycles, in_ready);
    end
    feed(8'h11, 1'b1);
    feed(8'h22, 1'b1);
    feed(8'h33, 1'b1);
    in_valid = 1'b0;
    compared++;
    if ({core_reset, in_ready, busy} !== 3'b001) begin
      mismatched++;
      $display("FAIL gaps_run: cr=%b rdy=%b busy=%b, required cr=0 rdy=0 busy=1", core_reset, in_ready, busy);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 40 && timed_out !== 1'b1; i++) tick();
    compared++;
    if ({timed_out, finished, core_reset, busy, cycles} !== {4'b1010, 16'd20}) begin
      mismatched++;
      $display("FAIL timeout: to=%b fin=%b cr=%b busy=%b cyc=%0d, required to=1 fin=0 cr=1 busy=0 cyc=20",
               timed_out, finished, core_reset, busy, cycles);
    end
    check_drained("timeout");
  endtask

  task automatic test_zero_len;
    do_start(0);
    compared++;
    if ({core_reset, busy, in_ready, mem_wr_en, timed_out} !== 5'b01000) begin
      mismatched++;
      $display("FAIL zero_len: cr/busy/rdy/we/to=%b, required 01000", {core_reset, busy, in_ready, mem_wr_en, timed_out});
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    compared++;
    if ({finished, cycles} !== {1'b1, 16'd0}) begin
      mismatched++;
      $display("FAIL zero_len_first_done: fin=%b cyc=%0d, required fin=1 cyc=0", finished, cycles);
    end
    do_start(0);
    for (int i = 0; i < 20; i++) tick();
    compared++;
    if ({cycles, busy, timed_out} !== {16'd20, 2'b10}) begin
      mismatched++;
      $display("FAIL at_limit: cyc=%0d busy=%b to=%b, required cyc=20 busy=1 to=0", cycles, busy, timed_out);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    compared++;
    if ({finished, timed_out, core_reset, cycles} !== {3'b101, 16'd20}) begin
      mismatched++;
      $display("FAIL done_at_limit: fin=%b to=%b cr=%b cyc=%0d, required fin=1 to=0 cr=1 cyc=20",
               finished, timed_out, core_reset, cycles);
    end
    check_drained("zero_len");
  endtask

  task automatic test_reset_mid;
    addr_exp = 0;
    do_start(5);
    feed(8'hC1, 1'b0);
    feed(8'hC2, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    compared++;
    if ({core_reset, in_ready, mem_wr_en, busy, finished, timed_out, mem_addr, mem_dat, cycles} !== {1'b1, 5'b0, 32'b0}) begin
      mismatched++;
      $display("FAIL async_reset: cr=%b rdy=%b we=%b busy=%b fin=%b to=%b addr=%0h dat=%0h cyc=%0d, required cr=1 rest 0",
               core_reset, in_ready, mem_wr_en, busy, finished, timed_out, mem_addr, mem_dat, cycles);
    end
    #1;
    reset = 1'b0;
    tick();
    addr_exp = 0;
    do_start(1);
    feed(8'h77, 1'b0);
    in_valid = 1'b0;
    compared++;
    if ({core_reset, mem_wr_en, mem_addr} !== {2'b01, 8'd0}) begin
      mismatched++;
      $display("FAIL reload_one: cr=%b we=%b addr=%0d, required cr=0 we=1 addr=0", core_reset, mem_wr_en, mem_addr);
    end
    tick();
    tick();
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_done();
    test_gaps();
    test_timeout();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
